// File: rtl/apb_slv_mem.sv
// APB4 completer backed by a byte-lane memory, with programmable wait states,
// address/protection error responses and a sticky protocol-violation flag.
module apb_slv_mem #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       DEPTH     = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter bit                PROT_CHK  = 1'b1
) (
    input  logic                pclk,
    input  logic                preset,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [ADDR_W-1:0]   paddr,
    input  logic [DATA_W-1:0]   pwdata,
    input  logic [DATA_W/8-1:0] pstrb,
    input  logic [2:0]          pprot,
    input  logic [3:0]          wait_cfg,
    output logic [DATA_W-1:0]   prdata,
    output logic                pready,
    output logic                pslverr,
    output logic                viol
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned LG    = $clog2(BYTES);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef logic [ADDR_W:0] wide_t;
    typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

    localparam wide_t                DEPTH_W   = wide_t'(DEPTH);
    localparam wide_t                HALF_W    = wide_t'(DEPTH / 2);
    localparam logic [ADDR_W-1:0]    LANE_MASK = ADDR_W'(BYTES - 1);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                err_q, err_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                pwrite_q, pwrite_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [BYTES-1:0]    pstrb_q, pstrb_d;
    logic [DATA_W-1:0]   prdata_q, prdata_d;
    logic                pready_q, pready_d;
    logic                pslverr_q, pslverr_d;
    logic                viol_q, viol_d;

    wide_t               off_w;
    wide_t               idx_full;
    logic                below_base;
    logic                out_of_range;
    logic                misaligned;
    logic                prot_err;
    logic                err_calc;
    logic [IDX_W-1:0]    rd_idx;
    logic [DATA_W-1:0]   rd_word;
    logic                wr_en;
    logic                unused_prot;

    assign unused_prot = ^{pprot[2], pprot[0]};

    // Decode at ADDR_W+1 bits so an address below the base cannot wrap into range.
    always_comb begin
        off_w        = {1'b0, paddr} - {1'b0, BASE_ADDR};
        idx_full     = off_w >> LG;
        below_base   = {1'b0, paddr} < {1'b0, BASE_ADDR};
        out_of_range = idx_full >= DEPTH_W;
        misaligned   = |(paddr & LANE_MASK);
        prot_err     = PROT_CHK && pprot[1] && (idx_full >= HALF_W);
        err_calc     = below_base | out_of_range | misaligned | prot_err;
        rd_idx       = idx_full[IDX_W-1:0];
    end

    assign wr_en = (state_q == ST_ACCESS) && pready_q && pwrite_q && !err_q;

    // One narrow array per byte lane keeps strobed writes a plain per-lane enable.
    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];

            always_ff @(posedge pclk) begin
                if (wr_en && pstrb_q[gi]) begin
                    mem[idx_q] <= pwdata_q[gi*8 +: 8];
                end
            end

            assign rd_word[gi*8 +: 8] = mem[rd_idx];
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        idx_d    = idx_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        pstrb_d  = pstrb_q;
        prdata_d = prdata_q;
        pready_d = 1'b0;
        viol_d   = viol_q;

        case (state_q)
            ST_IDLE: begin
                if (psel && !penable) begin
                    state_d  = ST_ACCESS;
                    pwrite_d = pwrite;
                    pwdata_d = pwdata;
                    pstrb_d  = pstrb;
                    idx_d    = rd_idx;
                    err_d    = err_calc;
                    cnt_d    = wait_cfg;
                    pready_d = (wait_cfg == 4'd0);
                    if (!pwrite) begin
                        prdata_d = err_calc ? '0 : rd_word;
                    end
                end else if (psel && penable) begin
                    viol_d = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (pready_q) begin
                    state_d = ST_IDLE;
                end else if (!psel) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                    viol_d  = 1'b1;
                end else begin
                    // pready is registered, so it rises on the edge that takes cnt to zero.
                    cnt_d    = cnt_q - 4'd1;
                    pready_d = (cnt_q == 4'd1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        pslverr_d = pready_d & err_d;
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            err_q     <= 1'b0;
            idx_q     <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            viol_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            idx_q     <= idx_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            viol_q    <= viol_d;
        end
    end

    assign prdata  = prdata_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;
    assign viol    = viol_q;

endmodule

// File: doc/apb_slv_mem.md
# apb_slv_mem

Parametrised APB4 completer with an internal byte-addressable memory, programmable wait states, address/protection error responses and protocol-violation detection. It is the synthesisable successor to the APB slave-side agent: it replaces a behavioural responder on the bridge's APB side with an RTL target. It sits directly on the AHB2APB bridge's APB master port in block and subsystem benches and can be instantiated per APB slot.

## Interface
Parameters:
- ADDR_W, 32, paddr width
- DATA_W, 32, data width; legal values 8, 16, 32, 64
- DEPTH, 256, number of DATA_W words; power of two, at least 2
- BASE_ADDR, 0, byte address of word 0; aligned to DATA_W/8
- PROT_CHK, 1, when 1, non-secure accesses to the upper half of memory return an error

Ports:
- pclk  in  1  clock; all state changes on the rising edge
- preset  in  1  asynchronous, active-high reset
- psel  in  1  slave select
- penable  in  1  access phase
- pwrite  in  1  1 = write, 0 = read
- paddr  in  ADDR_W  byte address
- pwdata  in  DATA_W  write data
- pstrb  in  DATA_W/8  write byte strobes; ignored on reads
- pprot  in  3  protection type; only bit 1 (non-secure) is used
- wait_cfg  in  4  wait states to insert; sampled at the setup edge
- prdata  out  DATA_W  read data
- pready  out  1  transfer complete
- pslverr  out  1  error response; only high while pready is high
- viol  out  1  sticky protocol-violation flag

## Operation
- States:
  - IDLE to ACCESS on an edge with psel=1 and penable=0 (setup sampled).
  - ACCESS to IDLE on an edge with pready=1 (completion) or with psel=0 (abort).
- At the setup edge, the block latches:
  - pwrite, pwdata and pstrb
  - the decoded word index: idx = (paddr - BASE_ADDR) >> log2(DATA_W/8)
  - the error flag err
  - cnt = wait_cfg
- err=1 if any of the following holds:
  - paddr < BASE_ADDR
  - idx >= DEPTH
  - the low log2(DATA_W/8) bits of paddr are non-zero
  - PROT_CHK=1, pprot[1]=1 and idx >= DEPTH/2
- Subtraction and comparison are done at ADDR_W+1 bits, so there is no wrap-around.
- Reads: at the setup edge, prdata is loaded with mem[idx], or 0 if err=1. prdata holds that value until the next setup edge.
- Writes: memory updates only at the completion edge with err=0. Byte lane b is written iff pstrb[b]=1; pstrb=0 is a legal no-op write. An errored write leaves memory unchanged.
- In ACCESS:
  - pready = (cnt==0).
  - cnt decrements on each edge while it is non-zero.
  - pslverr = pready & err.
- Abort: psel=0 in ACCESS before completion means no write, return to IDLE and set viol=1.
- Violation: penable=1 while in IDLE with psel=1 (access without a setup) also sets viol=1 and is otherwise ignored. viol clears only on reset.
- Memory array is not reset; contents are undefined until written.

## Timing
- Reset values: pready=0, pslverr=0, prdata=0, viol=0, state=IDLE, cnt=0.
- Zero-wait transfer:
  - setup in cycle T0;
  - ACCESS with pready=1 in T1;
  - transfer completes at the end of T1.
- With wait_cfg=N, pready is low for N ACCESS cycles and high in ACCESS cycle N+1.
- Back-to-back: a new setup is accepted in the cycle immediately after completion, so a sustained rate of one transfer per 2 cycles at N=0.
- A write followed by a read of the same address returns the new data. The write commits at completion, before the earliest following setup edge.
- wait_cfg changes during ACCESS do not affect the current transfer.
- Reset asserted mid-transfer: outputs go to reset values immediately (asynchronously), the pending write is dropped, and the state is IDLE.

## Test plan
- Zero-wait write then read: write 0xDEADBEEF to BASE_ADDR+0x10 with pstrb=0xF, wait_cfg=0, then read the same address -> pready high in the first access cycle both times, prdata=0xDEADBEEF, pslverr=0.
- Byte strobes: fill 0x11223344, then write 0xAABBCCDD with pstrb=0x5, then read -> 0x11BB33DD.
- Wait states: wait_cfg=3 on a read -> exactly 3 cycles with penable=1 and pready=0, then pready=1 with correct data; a wait_cfg change during the access has no effect.
- Errors:
  - paddr = BASE_ADDR + 4*DEPTH -> pslverr=1 with pready;
  - misaligned paddr=BASE_ADDR+0x2 -> pslverr=1;
  - a non-secure write to word DEPTH/2 with PROT_CHK=1 -> pslverr=1, and a later secure read still shows the old data;
  - reads with err return prdata=0.
- Protocol violations: drop psel during a wait state (wait_cfg=2) -> no write, viol=1, next valid transfer completes normally; penable=1 without setup -> viol=1.
- Reset mid-access: assert preset during a wait state of a write -> pready, pslverr, prdata and viol are 0 immediately, the word is unchanged, and a new transfer after deassertion completes normally.
